// File: rtl/comparator_nb_serial.sv
// Multi-cycle WIDTH-bit magnitude comparator: scans operands MSB-first, SLICE bits per
// cycle, stopping at the first differing slice. Supports unsigned and two's-complement modes.
module comparator_nb_serial #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_great_B,
    output logic             A_equal_B,
    output logic             A_less_B
);

    localparam int NSL   = WIDTH / SLICE;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("comparator_nb_serial: WIDTH must be >= 2 and a multiple of SLICE");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   idx;
    logic [SLICE-1:0]   slice_a;
    logic [SLICE-1:0]   slice_b;

    always_comb begin
        slice_a = a_q[int'(idx) * SLICE +: SLICE];
        slice_b = b_q[int'(idx) * SLICE +: SLICE];
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            A_great_B <= 1'b0;
            A_equal_B <= 1'b0;
            A_less_B  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Flipping both sign bits maps signed order onto unsigned order.
                        a_q       <= {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
                        b_q       <= {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
                        idx       <= IDX_W'(NSL - 1);
                        A_great_B <= 1'b0;
                        A_equal_B <= 1'b0;
                        A_less_B  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (slice_a > slice_b) begin
                        A_great_B <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if (slice_a < slice_b) begin
                        A_less_B  <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if (idx == '0) begin
                        A_equal_B <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    a_busy_done_exclusive: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    a_flags_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0({A_great_B, A_equal_B, A_less_B}));

endmodule

// File: tb/tb_comparator_nb_serial.sv
// Self-checking bench: two instances (SLICE=1 and SLICE=4, WIDTH=8) driven in lockstep,
// compared against an arithmetic reference for result flags, latency and handshake.
module tb_comparator_nb_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy_v [2];
    logic       done_v [2];
    logic       gt_v   [2];
    logic       eq_v   [2];
    logic       lt_v   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    comparator_nb_serial #(.WIDTH(8), .SLICE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(A), .B(B),
        .busy(busy_v[0]), .done(done_v[0]),
        .A_great_B(gt_v[0]), .A_equal_B(eq_v[0]), .A_less_B(lt_v[0])
    );

    comparator_nb_serial #(.WIDTH(8), .SLICE(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(A), .B(B),
        .busy(busy_v[1]), .done(done_v[1]),
        .A_great_B(gt_v[1]), .A_equal_B(eq_v[1]), .A_less_B(lt_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int slice_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // {gt, eq, lt} from plain integer comparison.
    function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b,
                                             input logic sm);
        int ia;
        int ib;
        ia = sm ? int'($signed(a)) : int'(a);
        ib = sm ? int'($signed(b)) : int'(b);
        if (ia > ib) return 3'b100;
        if (ia < ib) return 3'b001;
        return 3'b010;
    endfunction

    // 1-based position of the first differing slice from the MSB, or the slice count.
    function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input int sl);
        int nsl;
        int x;
        nsl = 8 / sl;
        x   = int'(a ^ b);
        for (int s = 0; s < nsl; s++) begin
            if (((x >> (8 - (s + 1) * sl)) & ((1 << sl) - 1)) != 0) return s + 1;
        end
        return nsl;
    endfunction

    function automatic logic [4:0] outs(input int d);
        return {busy_v[d], done_v[d], gt_v[d], eq_v[d], lt_v[d]};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input bit disturb);
        logic [2:0] exp_f;
        int         exp_lat [2];
        int         lat     [2];
        int         pulses  [2];
        int         viol    [2];
        logic [2:0] f;
        exp_f = ref_flags(a, b, sm);
        for (int d = 0; d < 2; d++) begin
            exp_lat[d] = ref_lat(a, b, slice_of(d));
            lat[d] = 0; pulses[d] = 0; viol[d] = 0;
        end
        @(negedge clk);
        A = a; B = b; signed_mode = sm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); signed_mode = 1'($urandom);
        for (int d = 0; d < 2; d++)
            check($sformatf("accept_s%0d", slice_of(d)), 32'(outs(d)), 32'b10000);
        for (int k = 1; k <= 10; k++) begin
            if (disturb && k == 3) begin
                start = 1'b1; A = 8'hFF; B = 8'h00; signed_mode = 1'b1;
            end else if (disturb && k == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                f = {gt_v[d], eq_v[d], lt_v[d]};
                if (done_v[d]) begin
                    pulses[d]++;
                    if (lat[d] == 0) lat[d] = k;
                    if (busy_v[d] || f !== exp_f) viol[d]++;
                end else if (lat[d] == 0) begin
                    if (busy_v[d] !== 1'b1 || f !== 3'b000) viol[d]++;
                end else begin
                    if (busy_v[d] !== 1'b0 || f !== exp_f) viol[d]++;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat_s%0d a=%h b=%h sm=%0d", slice_of(d), a, b, sm),
                  32'(lat[d]), 32'(exp_lat[d]));
            check($sformatf("pulses_s%0d", slice_of(d)), 32'(pulses[d]), 32'd1);
            check($sformatf("cycle_viol_s%0d", slice_of(d)), 32'(viol[d]), 32'd0);
            check($sformatf("flags_hold_s%0d a=%h b=%h sm=%0d", slice_of(d), a, b, sm),
                  32'({gt_v[d], eq_v[d], lt_v[d]}), 32'(exp_f));
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         dones;

        // Reset held with start high: nothing may run.
        rst = 1'b1; start = 1'b1; signed_mode = 1'b0; A = 8'h80; B = 8'h00;
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check($sformatf("reset_s%0d", slice_of(d)), 32'(outs(d)), 32'd0);
        end
        rst = 1'b0; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check($sformatf("idle_s%0d", slice_of(d)), 32'(outs(d)), 32'd0);
        end

        // Directed cases: mode-dependent MSB, worst case, slice boundaries.
        run_op(8'h80, 8'h7F, 1'b0, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1, 1'b0);
        run_op(8'hA5, 8'hA5, 1'b0, 1'b0);
        run_op(8'h10, 8'h11, 1'b0, 1'b0);
        run_op(8'h3D, 8'h3C, 1'b0, 1'b0);
        run_op(8'h4C, 8'h3C, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);

        // Start and operand changes during SCAN/DONE must be ignored.
        run_op(8'h01, 8'h02, 1'b0, 1'b1);

        // Mid-operation reset abandons the compare with no done.
        @(negedge clk);
        A = 8'h10; B = 8'h11; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            check($sformatf("midreset_s%0d", slice_of(d)), 32'(outs(d)), 32'd0);
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (done_v[d] || busy_v[d]) dones++;
        end
        check("after_midreset_activity", 32'(dones), 32'd0);
        run_op(8'h10, 8'h11, 1'b0, 1'b0);

        // Randomised operands, biased towards equal and single-bit differences.
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 8'(1 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            run_op(ra, rb, 1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
